// File: rtl/stopwatch_pkg.sv
// Shared definitions for the centisecond stopwatch.
// - state_t : FSM state encoding (IDLE/RUN/PAUSE/LAP)
// - bcd_time_t : packed MM:SS.cc BCD time, one 4-bit digit per field,
//   ordered {min_t,min_o,sec_t,sec_o,cs_t,cs_o} to match the display bus.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_o;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_o;
    logic [DIGIT_W-1:0] cs_t;
    logic [DIGIT_W-1:0] cs_o;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_tick_sync.sv
// Synchronises the asynchronous 100 Hz square wave into the clk domain and
// emits a single-cycle tick per rising edge.
// Ports:
//   clk, rst     : system clock, async active-high reset
//   i_tick_src   : asynchronous square wave
//   o_tick       : 1-cycle pulse, one per i_tick_src rising edge
module stopwatch_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick_src,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_tick_src};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Centisecond stopwatch: FSM (IDLE/RUN/PAUSE/LAP), MM:SS.cc BCD counter,
// lap snapshot and registered display mux.
// Ports:
//   clk, rst      : 100 MHz clock, async active-high reset
//   tick_src      : 100 Hz square wave from the divider (asynchronous)
//   btn_start     : start/stop toggle pulse
//   btn_lap       : lap freeze/release pulse
//   btn_clear     : clear-to-zero pulse (highest priority)
//   disp_digits   : {min_t,min_o,sec_t,sec_o,cs_t,cs_o} BCD, registered
//   state_o       : current FSM state code, registered
//   running       : 1 in RUN or LAP, registered
//   overflow      : sticky wrap flag, registered
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX     = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_src,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] disp_digits,
  output logic [1:0]  state_o,
  output logic        running,
  output logic        overflow
);

  localparam logic [DIGIT_W-1:0] MM_T = 4'(MIN_MAX / 10);
  localparam logic [DIGIT_W-1:0] MM_O = 4'(MIN_MAX % 10);

  state_t    r_state;
  bcd_time_t r_live;
  bcd_time_t r_snap;
  logic      r_ovf;

  logic      w_tick;
  bcd_time_t w_next;
  logic      w_wrap;

  stopwatch_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clk        (clk),
    .rst        (rst),
    .i_tick_src (tick_src),
    .o_tick     (w_tick)
  );

  // Live count + 1 centisecond, full ripple carry in one cycle.
  always_comb begin
    w_next = r_live;
    w_wrap = 1'b0;
    if (r_live.cs_o != DIGIT_MAX) begin
      w_next.cs_o = r_live.cs_o + 4'd1;
    end else begin
      w_next.cs_o = '0;
      if (r_live.cs_t != DIGIT_MAX) begin
        w_next.cs_t = r_live.cs_t + 4'd1;
      end else begin
        w_next.cs_t = '0;
        if (r_live.sec_o != DIGIT_MAX) begin
          w_next.sec_o = r_live.sec_o + 4'd1;
        end else begin
          w_next.sec_o = '0;
          if (r_live.sec_t != SEC_TENS_MAX) begin
            w_next.sec_t = r_live.sec_t + 4'd1;
          end else begin
            w_next.sec_t = '0;
            if (r_live.min_t == MM_T && r_live.min_o == MM_O) begin
              w_next.min_t = '0;
              w_next.min_o = '0;
              w_wrap       = 1'b1;
            end else if (r_live.min_o != DIGIT_MAX) begin
              w_next.min_o = r_live.min_o + 4'd1;
            end else begin
              w_next.min_o = '0;
              w_next.min_t = r_live.min_t + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_live      <= '0;
      r_snap      <= '0;
      r_ovf       <= 1'b0;
      disp_digits <= '0;
      state_o     <= '0;
      running     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // Outputs reflect the state/count registers one cycle later.
      disp_digits <= (r_state == LAP) ? r_snap : r_live;
      state_o     <= r_state;
      running     <= (r_state == RUN) || (r_state == LAP);
      overflow    <= r_ovf;

      if (btn_clear) begin
        r_state <= IDLE;
        r_live  <= '0;
        r_snap  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        // The count advances in RUN/LAP regardless of any button this cycle.
        if ((r_state == RUN || r_state == LAP) && w_tick) begin
          r_live <= w_next;
          if (w_wrap) r_ovf <= 1'b1;
        end
        case (r_state)
          IDLE:  if (btn_start) r_state <= RUN;
          RUN: begin
            if (btn_start) begin
              r_state <= PAUSE;
            end else if (btn_lap) begin
              r_state <= LAP;
              r_snap  <= w_tick ? w_next : r_live;
            end
          end
          PAUSE: if (btn_start) r_state <= RUN;
          LAP: begin
            if (btn_start)    r_state <= PAUSE;
            else if (btn_lap) r_state <= RUN;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
